// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit mux among four requesters.
// Drives registered mux select/grant lines and a registered data bit with valid.
module rr_mux_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic address0,
  output logic address1,
  output logic grant0,
  output logic grant1,
  output logic grant2,
  output logic grant3,
  output logic out,
  output logic out_valid,
  output logic busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [2:0] HOLD = 3'(HOLD_MAX);

  state_t     state, state_n;
  logic [1:0] addr, addr_n;
  logic [1:0] last, last_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] grant, grant_n;
  logic       out_r, valid_r;

  logic [3:0] req, din, others;
  logic [1:0] idle_pick, hand_pick;

  // Rotate the request vector so the slot after base lands at bit 0,
  // then take the lowest set bit and rotate the index back.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [7:0] dbl;
    logic [1:0] off;
    dbl = {r, r} >> (3'(base) + 3'd1);
    off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (dbl[i]) off = 2'(i);
    end
    return base + off + 2'd1;
  endfunction

  assign req       = {req3, req2, req1, req0};
  assign din       = {in3, in2, in1, in0};
  assign others    = req & ~(4'b0001 << addr);
  assign idle_pick = rr_pick(req, last);
  assign hand_pick = rr_pick(others, addr);

  always_comb begin
    state_n = state;
    addr_n  = addr;
    last_n  = last;
    cnt_n   = cnt;
    grant_n = grant;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          addr_n  = idle_pick;
          grant_n = 4'b0001 << idle_pick;
          cnt_n   = 3'd1;
        end
      end
      GRANT: begin
        if (!req[addr] || (cnt >= HOLD && |others)) begin
          last_n = addr;
          if (|others) begin
            addr_n  = hand_pick;
            grant_n = 4'b0001 << hand_pick;
            cnt_n   = 3'd1;
          end else begin
            state_n = IDLE;
            grant_n = 4'b0000;
            cnt_n   = 3'd0;
          end
        end else if (cnt < HOLD) begin
          cnt_n = cnt + 3'd1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr  <= 2'd0;
      last  <= 2'd3;
      cnt   <= 3'd0;
      grant <= 4'b0000;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      last  <= last_n;
      cnt   <= cnt_n;
      grant <= grant_n;
    end
  end

  // Data sampled through the current select; holds its value while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      if (state == GRANT) out_r <= din[addr];
      valid_r <= (state == GRANT);
    end
  end

  assign address0  = addr[0];
  assign address1  = addr[1];
  assign grant0    = grant[0];
  assign grant1    = grant[1];
  assign grant2    = grant[2];
  assign grant3    = grant[3];
  assign out       = out_r;
  assign out_valid = valid_r;
  assign busy      = (state == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus random traffic, all
// compared against a queue-free behavioural model of the arbitration rules.
module tb_rr_mux_arbiter;

  localparam int HOLD_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic req0, req1, req2, req3;
  logic in0, in1, in2, in3;
  logic address0, address1;
  logic grant0, grant1, grant2, grant3;
  logic out, out_valid, busy;

  int vectors = 0;
  int miscompares = 0;

  int m_owner = -1;
  int m_last  = 3;
  int m_cnt   = 0;
  int m_addr  = 0;
  bit m_out   = 1'b0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .address0(address0), .address1(address1),
    .grant0(grant0), .grant1(grant1), .grant2(grant2), .grant3(grant3),
    .out(out), .out_valid(out_valid), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Next requester after 'base' in circular order whose bit is set in r.
  function automatic int nextInRing(input int base, input bit [3:0] r);
    for (int step = 1; step <= 4; step++) begin
      if (r[(base + step) % 4]) return (base + step) % 4;
    end
    return -1;
  endfunction

  task automatic modelStep(input bit rst, input bit [3:0] r, input bit [3:0] d);
    bit [3:0] rest;
    int winner;
    if (rst) begin
      m_owner = -1; m_last = 3; m_cnt = 0; m_addr = 0;
      m_out = 1'b0; m_valid = 1'b0;
      return;
    end
    if (m_owner >= 0) m_out = d[m_owner];
    m_valid = (m_owner >= 0);
    if (m_owner < 0) begin
      winner = nextInRing(m_last, r);
      if (winner >= 0) begin
        m_owner = winner; m_addr = winner; m_cnt = 1;
      end
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (!r[m_owner] || (m_cnt == HOLD_MAX && rest != 4'b0)) begin
        m_last = m_owner;
        winner = nextInRing(m_owner, rest);
        if (winner >= 0) begin
          m_owner = winner; m_addr = winner; m_cnt = 1;
        end else begin
          m_owner = -1;
        end
      end else if (m_cnt < HOLD_MAX) begin
        m_cnt++;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit [3:0] r, input bit [3:0] d);
    logic [3:0] expGrant;
    reset = rst;
    {req3, req2, req1, req0} = r;
    {in3, in2, in1, in0} = d;
    @(posedge clk);
    #1;
    modelStep(rst, r, d);
    expGrant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    checkOutput("grant", {4'b0, grant3, grant2, grant1, grant0}, {4'b0, expGrant});
    checkOutput("address", {6'b0, address1, address0}, 8'(m_addr));
    checkOutput("busy", {7'b0, busy}, {7'b0, (m_owner >= 0)});
    checkOutput("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
    checkOutput("out", {7'b0, out}, {7'b0, m_out});
  endtask

  initial begin
    bit [3:0] r;
    bit [3:0] d;
    reset = 1'b1;
    {req3, req2, req1, req0} = 4'b0;
    {in3, in2, in1, in0} = 4'b0;

    // Reset, then a single requester.
    applyStimulus(1, 4'b0000, 4'b0000);
    applyStimulus(1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'b0100, 4'b0100);
    applyStimulus(0, 4'b0000, 4'b0100);
    applyStimulus(0, 4'b0000, 4'b0000);

    // Simultaneous requests rotate with bounded tenure.
    applyStimulus(1, 4'b0000, 4'b0000);
    for (int i = 0; i < 22; i++) applyStimulus(0, 4'b1111, 4'(i));

    // Early release hands off on the same edge.
    applyStimulus(1, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b0010, 4'b0010);
    applyStimulus(0, 4'b1010, 4'b1010);
    applyStimulus(0, 4'b1000, 4'b1000);
    applyStimulus(0, 4'b1000, 4'b0000);

    // Uncontended hold, then release to idle.
    applyStimulus(1, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) applyStimulus(0, 4'b0001, 4'(i % 2));
    applyStimulus(0, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b0000, 4'b0000);

    // Data tracking on a held grant; other inputs toggle freely.
    applyStimulus(1, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b0100, 4'b1011);
    applyStimulus(0, 4'b0100, 4'b0100);
    applyStimulus(0, 4'b0100, 4'b1011);
    applyStimulus(0, 4'b0100, 4'b0100);
    applyStimulus(0, 4'b0100, 4'b0000);

    // Reset in the middle of a grant; pointer returns to 3.
    applyStimulus(0, 4'b1000, 4'b1000);
    applyStimulus(0, 4'b1000, 4'b1000);
    applyStimulus(1, 4'b1000, 4'b1000);
    applyStimulus(0, 4'b1010, 4'b1010);
    applyStimulus(0, 4'b1010, 4'b1010);

    // Random traffic with sticky requests and occasional reset.
    r = 4'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      d = 4'($urandom);
      applyStimulus($urandom_range(0, 199) == 0, r, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
